// File: rtl/idct_writeback_pkg.sv
// Shared definitions for the IDCT write-back stage and its neighbours.
//   WB_state_type : write-back FSM states
//   wb_seg_e      : Y/U/V segment selector
//   *_BASE_DEF    : default first SRAM word of each colour segment
//   clip          : signed 32-bit sample -> unsigned 8-bit pixel
package idct_writeback_pkg;

    typedef enum logic [2:0] {
        S_WB_IDLE,
        S_WB_LEAD_IN_0,
        S_WB_LEAD_IN_1,
        S_WB_WRITE,
        S_WB_DONE
    } WB_state_type;

    typedef enum logic [1:0] {
        SEG_Y,
        SEG_U,
        SEG_V
    } wb_seg_e;

    localparam logic [17:0] Y_BASE_DEF = 18'd0;
    localparam logic [17:0] U_BASE_DEF = 18'd38400;
    localparam logic [17:0] V_BASE_DEF = 18'd57600;

    // Block grid: 30 block rows; Y has 40 block columns, U/V have 20.
    localparam logic [4:0] LAST_BROW    = 5'd29;
    localparam logic [5:0] LAST_BCOL_Y  = 6'd39;
    localparam logic [5:0] LAST_BCOL_UV = 6'd19;

    // Negative -> 0, anything above 255 -> 255, otherwise the low byte.
    function automatic logic [7:0] clip(input logic [31:0] sample);
        if (sample[31]) begin
            return 8'h00;
        end else if (|sample[30:8]) begin
            return 8'hFF;
        end else begin
            return sample[7:0];
        end
    endfunction

endpackage

// File: rtl/idct_writeback_if.sv
// Bus bundle between the write-back stage and its surroundings.
//   WB_start/WB_done/WB_all_done : block handshake
//   dpram_*                      : two read ports of the IDCT result DP-RAM
//   SRAM_*                       : external SRAM write port
// master = write-back stage, slave = controller / memories.
interface idct_writeback_if;
    logic        WB_start;
    logic        WB_done;
    logic        WB_all_done;
    logic [6:0]  dpram_address_a;
    logic [6:0]  dpram_address_b;
    logic [31:0] dpram_read_data_a;
    logic [31:0] dpram_read_data_b;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    modport master (
        input  WB_start, dpram_read_data_a, dpram_read_data_b,
        output WB_done, WB_all_done, dpram_address_a, dpram_address_b,
        output SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport slave (
        output WB_start, dpram_read_data_a, dpram_read_data_b,
        input  WB_done, WB_all_done, dpram_address_a, dpram_address_b,
        input  SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/idct_writeback_addr_gen.sv
// Block position counters and SRAM address generation.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   advance_i     : step to the next block (one pulse per finished block)
//   row_i, k_i    : row inside the block and pixel-pair index inside the row
//   addr_o        : SRAM word address for (row_i, k_i) of the current block
//   all_done_o    : sticky, set when the last V block has been stepped past
module idct_writeback_addr_gen
    import idct_writeback_pkg::*;
#(
    parameter logic [17:0] Y_BASE = Y_BASE_DEF,
    parameter logic [17:0] U_BASE = U_BASE_DEF,
    parameter logic [17:0] V_BASE = V_BASE_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        advance_i,
    input  logic [2:0]  row_i,
    input  logic [1:0]  k_i,
    output logic [17:0] addr_o,
    output logic        all_done_o
);

    wb_seg_e     seg_q, seg_d;
    logic [4:0]  brow_q, brow_d;
    logic [5:0]  bcol_q, bcol_d;
    logic        all_done_q, all_done_d;

    logic [5:0]  last_bcol;
    logic [17:0] seg_base;
    logic [17:0] line;
    logic [17:0] row_off;

    always_comb begin
        last_bcol  = (seg_q == SEG_Y) ? LAST_BCOL_Y : LAST_BCOL_UV;
        seg_d      = seg_q;
        brow_d     = brow_q;
        bcol_d     = bcol_q;
        all_done_d = all_done_q;
        if (advance_i) begin
            if (bcol_q != last_bcol) begin
                bcol_d = bcol_q + 6'd1;
            end else begin
                bcol_d = 6'd0;
                if (brow_q != LAST_BROW) begin
                    brow_d = brow_q + 5'd1;
                end else begin
                    brow_d = 5'd0;
                    case (seg_q)
                        SEG_Y:   seg_d = SEG_U;
                        SEG_U:   seg_d = SEG_V;
                        default: begin
                            seg_d      = SEG_Y;
                            all_done_d = 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    // Pixel line = brow*8 + row; stride 160 = 128+32, 80 = 64+16.
    always_comb begin
        case (seg_q)
            SEG_Y:   seg_base = Y_BASE;
            SEG_U:   seg_base = U_BASE;
            default: seg_base = V_BASE;
        endcase
        line    = {10'd0, brow_q, row_i};
        row_off = (seg_q == SEG_Y) ? (line << 7) + (line << 5) : (line << 6) + (line << 4);
        addr_o  = seg_base + row_off + {10'd0, bcol_q, 2'b00} + {16'd0, k_i};
    end

    assign all_done_o = all_done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seg_q      <= SEG_Y;
            brow_q     <= 5'd0;
            bcol_q     <= 6'd0;
            all_done_q <= 1'b0;
        end else begin
            seg_q      <= seg_d;
            brow_q     <= brow_d;
            bcol_q     <= bcol_d;
            all_done_q <= all_done_d;
        end
    end

endmodule

// File: rtl/idct_writeback.sv
// IDCT write-back: copies one 8x8 block of clipped IDCT samples from the
// DP-RAM into the Y/U/V frame buffer in SRAM, two pixels per word.
//   CLOCK_50_I : clock
//   resetn     : asynchronous active-low reset
//   wb         : handshake, DP-RAM read ports and SRAM write port
// All SRAM-side outputs are registered, so each write appears one cycle
// after the S_WB_WRITE cycle that computed it.
module idct_writeback
    import idct_writeback_pkg::*;
#(
    parameter logic [17:0] Y_BASE = Y_BASE_DEF,
    parameter logic [17:0] U_BASE = U_BASE_DEF,
    parameter logic [17:0] V_BASE = V_BASE_DEF
) (
    input  logic           CLOCK_50_I,
    input  logic           resetn,
    idct_writeback_if.master wb
);

    WB_state_type state_q, state_d;
    logic [4:0]   wcnt_q, wcnt_d;
    logic [6:0]   addr_a_q, addr_a_d;
    logic [6:0]   addr_b_q, addr_b_d;
    logic [17:0]  sram_addr_q, sram_addr_d;
    logic [15:0]  sram_wdata_q, sram_wdata_d;
    logic         sram_we_n_q, sram_we_n_d;
    logic         wb_done_q, wb_done_d;

    logic         advance;
    logic [17:0]  gen_addr;
    logic         all_done;

    idct_writeback_addr_gen #(
        .Y_BASE (Y_BASE),
        .U_BASE (U_BASE),
        .V_BASE (V_BASE)
    ) u_wb_addr_gen (
        .clk_i      (CLOCK_50_I),
        .rst_ni     (resetn),
        .advance_i  (advance),
        .row_i      (wcnt_q[4:2]),
        .k_i        (wcnt_q[1:0]),
        .addr_o     (gen_addr),
        .all_done_o (all_done)
    );

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_we_n_d  = 1'b1;
        wb_done_d    = 1'b0;
        advance      = 1'b0;

        // Port B carries the odd column; once 63 is out the reads are complete.
        if (state_q inside {S_WB_LEAD_IN_0, S_WB_LEAD_IN_1, S_WB_WRITE} && addr_b_q != 7'd63) begin
            addr_a_d = addr_a_q + 7'd2;
            addr_b_d = addr_b_q + 7'd2;
        end

        case (state_q)
            S_WB_IDLE: begin
                if (wb.WB_start && !all_done) begin
                    addr_a_d = 7'd0;
                    addr_b_d = 7'd1;
                    state_d  = S_WB_LEAD_IN_0;
                end
            end
            S_WB_LEAD_IN_0: state_d = S_WB_LEAD_IN_1;
            S_WB_LEAD_IN_1: begin
                wcnt_d  = 5'd0;
                state_d = S_WB_WRITE;
            end
            S_WB_WRITE: begin
                sram_we_n_d  = 1'b0;
                sram_addr_d  = gen_addr;
                sram_wdata_d = {clip(wb.dpram_read_data_a), clip(wb.dpram_read_data_b)};
                wcnt_d       = wcnt_q + 5'd1;
                if (wcnt_q == 5'd31) begin
                    state_d = S_WB_DONE;
                end
            end
            S_WB_DONE: begin
                wb_done_d = 1'b1;
                advance   = 1'b1;
                state_d   = S_WB_IDLE;
            end
            default: state_d = S_WB_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_WB_IDLE;
            wcnt_q       <= 5'd0;
            addr_a_q     <= 7'd0;
            addr_b_q     <= 7'd0;
            sram_addr_q  <= 18'd0;
            sram_wdata_q <= 16'd0;
            sram_we_n_q  <= 1'b1;
            wb_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_n_q  <= sram_we_n_d;
            wb_done_q    <= wb_done_d;
        end
    end

    assign wb.dpram_address_a = addr_a_q;
    assign wb.dpram_address_b = addr_b_q;
    assign wb.SRAM_address    = sram_addr_q;
    assign wb.SRAM_write_data = sram_wdata_q;
    assign wb.SRAM_we_n       = sram_we_n_q;
    assign wb.WB_done         = wb_done_q;
    assign wb.WB_all_done     = all_done;

endmodule

// File: tb/tb_idct_writeback.sv
// Directed bench for idct_writeback: DP-RAM model with two-edge read
// latency, SRAM write monitor, and a reference address/data model.
module tb_idct_writeback;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #10 clk = ~clk;

    idct_writeback_if bus ();

    idct_writeback dut (
        .CLOCK_50_I (clk),
        .resetn     (resetn),
        .wb         (bus)
    );

    // DP-RAM model: address registered on one edge, data out on the next.
    logic [31:0] mem [64];
    logic [31:0] s1_a = 32'd0, s1_b = 32'd0, q_a = 32'd0, q_b = 32'd0;
    always @(posedge clk) begin
        s1_a <= mem[bus.dpram_address_a[5:0]];
        s1_b <= mem[bus.dpram_address_b[5:0]];
        q_a  <= s1_a;
        q_b  <= s1_b;
    end
    assign bus.dpram_read_data_a = q_a;
    assign bus.dpram_read_data_b = q_b;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference SRAM address for write w (0..31) of block n (0..2399).
    function automatic logic [17:0] exp_addr(input int n, input int w);
        int m, base, stride, bpr;
        if (n < 1200) begin
            m = n; base = 0; stride = 160; bpr = 40;
        end else if (n < 1800) begin
            m = n - 1200; base = 38400; stride = 80; bpr = 20;
        end else begin
            m = n - 1800; base = 57600; stride = 80; bpr = 20;
        end
        return 18'(base + ((m / bpr) * 8 + w / 4) * stride + (m % bpr) * 4 + w % 4);
    endfunction

    // Reference word for write w when DP-RAM holds r*8+c.
    function automatic logic [15:0] exp_word(input int w);
        int r, k;
        r = w / 4;
        k = w % 4;
        return {8'(r * 8 + 2 * k), 8'(r * 8 + 2 * k + 1)};
    endfunction

    // Write monitor
    logic [17:0] wr_addr [32];
    logic [15:0] wr_data [32];
    int tot_wr = 0, blk_base = 0, first_edge = 0, last_edge = 0, done_edge = 0, done_cnt = 0;
    bit long_mode = 1'b0;
    int lng_wr = 0, lng_done = 0, lng_errs = 0, gap_errs = 0, prev_done = 0;
    logic [17:0] u_first = '0, u2_first = '0, last_addr = '0;
    logic all_before = 1'b1, all_after = 1'b0;

    always @(negedge clk) begin
        if (!bus.SRAM_we_n) begin
            if (tot_wr - blk_base >= 0 && tot_wr - blk_base < 32) begin
                wr_addr[tot_wr - blk_base] <= bus.SRAM_address;
                wr_data[tot_wr - blk_base] <= bus.SRAM_write_data;
            end
            if (tot_wr == blk_base) first_edge <= edge_cnt;
            last_edge <= edge_cnt;
            tot_wr <= tot_wr + 1;
            if (long_mode) begin
                if (bus.SRAM_address !== exp_addr(lng_wr / 32, lng_wr % 32) ||
                    bus.SRAM_write_data !== exp_word(lng_wr % 32))
                    lng_errs <= lng_errs + 1;
                if (lng_wr == 1200 * 32) u_first <= bus.SRAM_address;
                if (lng_wr == 1201 * 32) u2_first <= bus.SRAM_address;
                last_addr <= bus.SRAM_address;
                lng_wr <= lng_wr + 1;
            end
        end
        if (bus.WB_done) begin
            done_edge <= edge_cnt;
            done_cnt  <= done_cnt + 1;
            if (long_mode) begin
                if (lng_done > 0 && edge_cnt - prev_done != 36) gap_errs <= gap_errs + 1;
                prev_done <= edge_cnt;
                if (lng_done == 2398) all_before <= bus.WB_all_done;
                if (lng_done == 2399) all_after <= bus.WB_all_done;
                lng_done <= lng_done + 1;
            end
        end
    end

    task automatic fill_pattern();
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
    endtask

    // One start pulse; returns the sampling edge and whether WB_done arrived.
    task automatic run_block(output int e0, output bit ok);
        int d0;
        blk_base = tot_wr;
        d0 = done_cnt;
        @(negedge clk);
        bus.WB_start = 1'b1;
        e0 = edge_cnt + 1;
        @(negedge clk);
        bus.WB_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (done_cnt != d0) ok = 1'b1;
        end
    endtask

    initial begin
        int e0;
        bit ok;
        int snap_wr, snap_done;

        bus.WB_start = 1'b0;
        fill_pattern();
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_we_n", 32'(bus.SRAM_we_n), 32'd1);
        check_eq("rst_addr", 32'(bus.SRAM_address), 32'd0);
        check_eq("rst_wdata", 32'(bus.SRAM_write_data), 32'd0);
        check_eq("rst_dp_a", 32'(bus.dpram_address_a), 32'd0);
        check_eq("rst_dp_b", 32'(bus.dpram_address_b), 32'd0);
        check_eq("rst_done", 32'(bus.WB_done), 32'd0);
        check_eq("rst_all_done", 32'(bus.WB_all_done), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Block 0 with r*8+c contents
        run_block(e0, ok);
        check_eq("b0_done_seen", 32'(ok), 32'd1);
        check_eq("b0_nwrites", 32'(tot_wr - blk_base), 32'd32);
        check_eq("b0_first_edge", 32'(first_edge - e0), 32'd3);
        check_eq("b0_last_edge", 32'(last_edge - e0), 32'd34);
        check_eq("b0_done_edge", 32'(done_edge - e0), 32'd35);
        for (int w = 0; w < 32; w++) begin
            check_eq($sformatf("b0_addr%0d", w), 32'(wr_addr[w]), 32'(exp_addr(0, w)));
            check_eq($sformatf("b0_data%0d", w), 32'(wr_data[w]), 32'(exp_word(w)));
        end
        check_eq("b0_word0", 32'(wr_data[0]), 32'h0001);
        check_eq("b0_word_last", 32'(wr_data[31]), 32'h3E3F);
        check_eq("b0_addr_last", 32'(wr_addr[31]), 32'd1123);

        // Block 1: clipping of -5, 300, 255, 0
        mem[0] = 32'hFFFF_FFFB;
        mem[1] = 32'd300;
        mem[2] = 32'd255;
        mem[3] = 32'd0;
        run_block(e0, ok);
        check_eq("clip_done_seen", 32'(ok), 32'd1);
        check_eq("clip_word0", 32'(wr_data[0]), 32'h00FF);
        check_eq("clip_word1", 32'(wr_data[1]), 32'hFF00);
        check_eq("clip_addr0", 32'(wr_addr[0]), 32'd4);
        check_eq("clip_addr1", 32'(wr_addr[1]), 32'd5);

        // Reset in the middle of block 2
        fill_pattern();
        blk_base = tot_wr;
        @(negedge clk);
        bus.WB_start = 1'b1;
        @(negedge clk);
        bus.WB_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (tot_wr - blk_base >= 10) ok = 1'b1;
        end
        check_eq("mid_reached_w10", 32'(ok), 32'd1);
        check_eq("mid_we_before", 32'(bus.SRAM_we_n), 32'd0);
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_we_n", 32'(bus.SRAM_we_n), 32'd1);
        check_eq("mid_rst_addr", 32'(bus.SRAM_address), 32'd0);
        check_eq("mid_rst_dp_a", 32'(bus.dpram_address_a), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_block(e0, ok);
        check_eq("restart_done_seen", 32'(ok), 32'd1);
        check_eq("restart_addr0", 32'(wr_addr[0]), 32'd0);
        check_eq("restart_nwrites", 32'(tot_wr - blk_base), 32'd32);

        // Full frame with start held high
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        long_mode = 1'b1;
        bus.WB_start = 1'b1;
        for (int i = 0; i < 2400 * 36 + 100 && lng_done < 2400; i++) @(negedge clk);
        check_eq("full_blocks", 32'(lng_done), 32'd2400);
        check_eq("full_writes", 32'(lng_wr), 32'd76800);
        check_eq("full_model_errs", 32'(lng_errs), 32'd0);
        check_eq("full_done_gap_errs", 32'(gap_errs), 32'd0);
        check_eq("u_first_addr", 32'(u_first), 32'd38400);
        check_eq("u_second_addr", 32'(u2_first), 32'd38404);
        check_eq("last_addr", 32'(last_addr), 32'd76799);
        check_eq("all_done_before_last", 32'(all_before), 32'd0);
        check_eq("all_done_at_last", 32'(all_after), 32'd1);
        snap_wr = tot_wr;
        snap_done = done_cnt;
        repeat (80) @(negedge clk);
        check_eq("post_all_no_writes", 32'(tot_wr - snap_wr), 32'd0);
        check_eq("post_all_no_done", 32'(done_cnt - snap_done), 32'd0);
        check_eq("post_all_level", 32'(bus.WB_all_done), 32'd1);
        bus.WB_start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/idct_writeback.md
IDCT_WRITEBACK -- requirements
Module: idct_writeback

Interface
REQ-001 Parameter Y_BASE, default 18'd0, first SRAM word of the Y segment.
REQ-002 Parameter U_BASE, default 18'd38400, first SRAM word of the U segment.
REQ-003 Parameter V_BASE, default 18'd57600, first SRAM word of the V segment.
REQ-004 CLOCK_50_I  in  1  sole clock, rising edge.
REQ-005 resetn  in  1  reset, asynchronous and active-low.
REQ-006 WB_start  in  1  request to write back one 8x8 block; sampled only in S_WB_IDLE.
REQ-007 dpram_address_a  out  7  DP-RAM port A read address (even columns).
REQ-008 dpram_address_b  out  7  DP-RAM port B read address (odd columns).
REQ-009 dpram_read_data_a  in  32  signed IDCT sample from port A.
REQ-010 dpram_read_data_b  in  32  signed IDCT sample from port B.
REQ-011 SRAM_address  out  18  SRAM word address.
REQ-012 SRAM_write_data  out  16  packed pixel pair.
REQ-013 SRAM_we_n  out  1  SRAM write enable, active-low.
REQ-014 WB_done  out  1  one-cycle pulse after a block's last write.
REQ-015 WB_all_done  out  1  level; high once all 2400 blocks are written.

Function
REQ-016 DP-RAM layout: sample (r,c) is at address r*8+c, with r,c in 0..7.
REQ-017 DP-RAM read latency: data is valid on read_data two clock edges after the address register changes.
REQ-018 Clip each sample: bit31=1 -> 8'h00; value >255 -> 8'hFF; otherwise bits [7:0].
REQ-019 SRAM_write_data = {clip(col 2k), clip(col 2k+1)}; the even column goes in [15:8].
REQ-020 Block order: Y 30 rows x 40 cols, then U 30x20, then V 30x20, each row-major; 2400 blocks total.
REQ-021 Row stride in words: Y 160, U/V 80.
REQ-022 SRAM_address = seg_base + (brow*8+r)*stride + bcol*4 + k, with k in 0..3.
REQ-023 Address arithmetic is unsigned 18-bit; multiplies by stride use shift-add only, no multiplier.
REQ-024 States: S_WB_IDLE, S_WB_LEAD_IN_0, S_WB_LEAD_IN_1, S_WB_WRITE, S_WB_DONE.
REQ-025 S_WB_IDLE: SRAM_we_n=1; on WB_start=1 and WB_all_done=0, load port addresses 0 and 1, then go to LEAD_IN_0.
REQ-026 LEAD_IN_0 / LEAD_IN_1: advance both port addresses by 2 each cycle; no write.
REQ-027 S_WB_WRITE: one SRAM write per cycle (SRAM_we_n=0) for exactly 32 cycles, raster order r then k; port addresses keep advancing by 2 until 63 has been issued.
REQ-028 Timing: WB_start sampled at edge 0 -> first write cycle follows edge 3, last write follows edge 34, WB_done high for the cycle after edge 35.
REQ-029 S_WB_DONE: SRAM_we_n=1 and WB_done=1; block column/row/segment counters advance; return to IDLE.
REQ-030 Counter wrap: bcol wraps at 40 (Y) or 20 (U/V) and increments brow; brow wraps at 30 and advances segment Y->U->V.
REQ-031 After the V block at row 29, col 19: WB_all_done=1 and held; further WB_start is ignored.
REQ-032 WB_start while not in IDLE is ignored; it is not queued.
REQ-033 The DP-RAM may be refilled once WB_done is seen; no sample is read after edge 34.

Reset
REQ-034 During reset, mid-block included: state=S_WB_IDLE, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, dpram_address_a/b=0, WB_done=0, WB_all_done=0, all block counters=0.
REQ-035 A partially written block is not resumed; the next WB_start writes block 0 of Y.

Structure
REQ-036 State enum WB_state_type and the Y/U/V base addresses belong in the shared define_state.h package, beside the M1 state type.
REQ-037 The clip function belongs in the shared package for reuse by the colour-space stage.
REQ-038 Sub-module wb_addr_gen: block counters plus SRAM address computation.
REQ-039 Target size: 150-300 lines.

Verification
REQ-040 First block: DP-RAM holds r*8+c; one start -> 32 writes at 0..3, 160..163, ..., 1120..1123; word 0 = 16'h0001, last word = 16'h3E3F; WB_done at cycle 35.
REQ-041 Clipping: samples -5, 300, 255, 0 in cols 0..3 -> word 0 = 16'h00FF, word 1 = 16'hFF00.
REQ-042 Y->U transition: 1200 blocks then one more -> first write address 38400; block 1201 starts at 38404.
REQ-043 Completion: 2400 blocks -> WB_all_done=1 after the last WB_done, last address 57600+239*80+79 = 76799; a following WB_start produces no writes.
REQ-044 Reset mid-block: resetn low at write 10 -> SRAM_we_n=1 immediately; the next start rewrites from address 0.
REQ-045 WB_start held high throughout -> back-to-back blocks with exactly one S_WB_DONE cycle and one S_WB_IDLE cycle between them.
